// File: rtl/mp_seq_pkg.sv
// Shared definitions for the multi-byte sequencer and the external byte ALU:
// FSM state codes, op_i encoding and the 5-bit ALU command set.
package mp_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_LSL = 2'b10,
    OP_LSR = 2'b11
  } op_e;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_LSL = 5'b00110;
  localparam logic [4:0] ALU_LSR = 5'b00111;
  localparam logic [4:0] ALU_MOV = 5'b01000;

  function automatic logic [4:0] alu_cmd_of(input op_e op);
    logic [4:0] cmd;
    case (op)
      OP_ADD:  cmd = ALU_ADD;
      OP_SUB:  cmd = ALU_SUB;
      OP_LSL:  cmd = ALU_LSL;
      default: cmd = ALU_LSR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/mp_seq_if.sv
// Request, ALU and result-write signals of the multi-byte sequencer.
// slave: the sequencer itself; master: the integrating datapath / ALU side.
interface mp_seq_if;
  logic       start_i;
  logic [1:0] op_i;
  logic [2:0] len_i;
  logic       cin_i;
  logic [2:0] rd_idx_o;
  logic [4:0] alu_cmd_o;
  logic       alu_sc_o;
  logic [7:0] alu_rslt_i;
  logic       alu_sc_i;
  logic       alu_zero_i;
  logic       wr_en_o;
  logic [2:0] wr_idx_o;
  logic [7:0] wr_data_o;
  logic       busy_o;
  logic       done_o;
  logic       carry_o;
  logic       zero_o;

  modport slave (
    input  start_i, op_i, len_i, cin_i, alu_rslt_i, alu_sc_i, alu_zero_i,
    output rd_idx_o, alu_cmd_o, alu_sc_o, wr_en_o, wr_idx_o, wr_data_o,
           busy_o, done_o, carry_o, zero_o
  );

  modport master (
    output start_i, op_i, len_i, cin_i, alu_rslt_i, alu_sc_i, alu_zero_i,
    input  rd_idx_o, alu_cmd_o, alu_sc_o, wr_en_o, wr_idx_o, wr_data_o,
           busy_o, done_o, carry_o, zero_o
  );
endinterface

// File: rtl/mp_seq.sv
// Multi-byte ALU sequencer: issues len+1 bytes to an external ALU, chaining carry/shift.
// Optional MP_SEQ_ZERO_EN adds an aggregate zero flag over all issued bytes.
//
// state    | meaning
// IDLE     | waiting for start_i; ALU sees MOV
// RUN      | one byte issued per cycle, previous result written back
// FLUSH    | last result write, done_o pulse, carry_o valid
module mp_seq
  import mp_seq_pkg::*;
(
  input logic    clk,
  input logic    rst_n,
  mp_seq_if.slave bus
);

  logic [1:0] state;
  op_e        op_q;
  logic [2:0] len_q;
  logic [2:0] cnt;
  logic       cin_q;
  logic       sc_q;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [7:0] wr_data;
  logic       done;
  logic       carry;
  logic [2:0] rd_idx;
  logic       running;

  assign running = (state == ST_RUN);
  // LSR walks MSB first so the shift-out ripples down toward byte 0
  assign rd_idx  = !running ? 3'd0 : (op_q == OP_LSR) ? (len_q - cnt) : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= OP_ADD;
      len_q   <= 3'd0;
      cnt     <= 3'd0;
      cin_q   <= 1'b0;
      sc_q    <= 1'b0;
      wr_en   <= 1'b0;
      wr_idx  <= 3'd0;
      wr_data <= 8'd0;
      done    <= 1'b0;
      carry   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start_i) begin
            op_q  <= op_e'(bus.op_i);
            len_q <= bus.len_i;
            cin_q <= bus.cin_i;
            cnt   <= 3'd0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          wr_en   <= 1'b1;
          wr_idx  <= rd_idx;
          wr_data <= bus.alu_rslt_i;
          sc_q    <= bus.alu_sc_i;
          if (cnt == len_q) begin
            done  <= 1'b1;
            carry <= bus.alu_sc_i;
            state <= ST_FLUSH;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_FLUSH: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_idx_o  = rd_idx;
  assign bus.alu_cmd_o = running ? alu_cmd_of(op_q) : ALU_MOV;
  assign bus.alu_sc_o  = running ? ((cnt == 3'd0) ? cin_q : sc_q) : 1'b0;
  assign bus.wr_en_o   = wr_en;
  assign bus.wr_idx_o  = wr_idx;
  assign bus.wr_data_o = wr_data;
  assign bus.busy_o    = (state != ST_IDLE);
  assign bus.done_o    = done;
  assign bus.carry_o   = carry;

`ifdef MP_SEQ_ZERO_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (state == ST_IDLE && bus.start_i) begin
      zero_q <= 1'b1;
    end else if (running) begin
      zero_q <= zero_q & bus.alu_zero_i;
    end
  end

  assign bus.zero_o = zero_q;
`else
  logic unused_zero;
  assign unused_zero = bus.alu_zero_i;
  assign bus.zero_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mp_seq.sv
// Bench for mp_seq: behavioural byte ALU, whole-operand arithmetic reference model,
// per-cycle compare process, plus directed scenarios with literal expectations.
module tb_mp_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic [63:0] opa, opb;
  int n_checks = 0;
  int n_pass = 0;

  mp_seq_if bus();

  mp_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // byte ALU
  logic [7:0] a_b, b_b;
  logic [8:0] alu9;
  always_comb begin
    a_b  = opa[8*bus.rd_idx_o +: 8];
    b_b  = opb[8*bus.rd_idx_o +: 8];
    alu9 = {1'b0, a_b};
    case (bus.alu_cmd_o)
      5'b00000: alu9 = {1'b0, a_b} + {1'b0, b_b} + {8'd0, bus.alu_sc_o};
      5'b00001: alu9 = {1'b0, a_b} + {1'b0, ~b_b} + {8'd0, bus.alu_sc_o};
      5'b00110: alu9 = {a_b, bus.alu_sc_o};
      5'b00111: alu9 = {a_b[0], bus.alu_sc_o, a_b[7:1]};
      default:  alu9 = {1'b0, a_b};
    endcase
  end
  assign bus.alu_rslt_i = alu9[7:0];
  assign bus.alu_sc_i   = alu9[8];
  assign bus.alu_zero_i = (alu9[7:0] == 8'd0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // reference model: whole-operand arithmetic, position in the operation timeline
  int          m_pos = -1;
  int          m_n = 1;
  logic [1:0]  m_op = 2'b00;
  logic [2:0]  m_len = 3'd0;
  logic        m_cin = 1'b0;
  logic [72:0] m_a, m_b, m_res;
  logic        m_rc, m_rz;
  logic        m_carry = 1'b0;
  logic        m_zero = 1'b0;

  function automatic int issue_idx(input int k);
    return (m_op == 2'b11) ? int'(m_len) - k : k;
  endfunction

  function automatic logic exp_sc(input int k);
    logic [72:0] mk, bb, s;
    if (k == 0) return m_cin;
    case (m_op)
      2'b00, 2'b01: begin
        mk = (73'd1 << (8*k)) - 73'd1;
        bb = (m_op == 2'b01) ? ~m_b : m_b;
        s  = (m_a & mk) + (bb & mk) + {72'd0, m_cin};
        return s[8*k];
      end
      2'b10:   return m_a[8*k-1];
      default: return m_a[8*(int'(m_len) - k + 1)];
    endcase
  endfunction

  task automatic model_accept();
    int w;
    logic [72:0] mask, full;
    m_op  = bus.op_i;
    m_len = bus.len_i;
    m_cin = bus.cin_i;
    m_n   = int'(m_len) + 1;
    w     = 8 * m_n;
    mask  = (73'd1 << w) - 73'd1;
    m_a   = {9'd0, opa} & mask;
    m_b   = {9'd0, opb} & mask;
    case (m_op)
      2'b00:   begin full = m_a + m_b + {72'd0, m_cin};           m_rc = full[w]; end
      2'b01:   begin full = m_a + (~m_b & mask) + {72'd0, m_cin}; m_rc = full[w]; end
      2'b10:   begin full = (m_a << 1) | {72'd0, m_cin};          m_rc = m_a[w-1]; end
      default: begin full = (m_a >> 1) | ({72'd0, m_cin} << (w-1)); m_rc = m_a[0]; end
    endcase
    m_res = full & mask;
`ifdef MP_SEQ_ZERO_EN
    m_rz = (m_res == 73'd0);
`else
    m_rz = 1'b0;
`endif
    m_pos = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos   = -1;
      m_carry = 1'b0;
      m_zero  = 1'b0;
    end else if (m_pos < 0) begin
      if (bus.start_i) model_accept();
    end else if (m_pos == m_n) begin
      m_pos = -1;
    end else begin
      m_pos++;
      if (m_pos == m_n) begin
        m_carry = m_rc;
        m_zero  = m_rz;
      end
    end
  end

  always @(negedge clk) begin
    logic run;
    int   wi;
    run = (m_pos >= 0) && (m_pos < m_n);
    chk("busy", bus.busy_o, (m_pos >= 0));
    chk("done", bus.done_o, (m_pos == m_n));
    chk("rd_idx", bus.rd_idx_o, run ? issue_idx(m_pos) : 0);
    chk("alu_cmd", bus.alu_cmd_o,
        !run ? 5'b01000 : (m_op == 2'b00) ? 5'b00000 : (m_op == 2'b01) ? 5'b00001 :
        (m_op == 2'b10) ? 5'b00110 : 5'b00111);
    if (run) chk("alu_sc", bus.alu_sc_o, exp_sc(m_pos));
    chk("wr_en", bus.wr_en_o, (m_pos >= 1));
    if (m_pos >= 1) begin
      wi = issue_idx(m_pos - 1);
      chk("wr_idx", bus.wr_idx_o, wi);
      chk("wr_data", bus.wr_data_o, m_res[8*wi +: 8]);
    end
    if (m_pos < 0 || m_pos == m_n) begin
      chk("carry", bus.carry_o, m_carry);
      chk("zero", bus.zero_o, m_zero);
    end
  end

  // monitors for directed scenarios
  logic [10:0] wlog[$];
  logic [2:0]  rlog[$];
  int          dcount = 0;
  always @(negedge clk) begin
    if (bus.wr_en_o) wlog.push_back({bus.wr_idx_o, bus.wr_data_o});
    if (bus.busy_o && !bus.done_o) rlog.push_back(bus.rd_idx_o);
    if (bus.done_o) dcount++;
  end

  task automatic do_op(input logic [1:0] op, input logic [2:0] len, input logic c,
                       input logic [63:0] a, input logic [63:0] b, input bit noise,
                       output int lat);
    @(posedge clk); #1;
    bus.op_i = op; bus.len_i = len; bus.cin_i = c; opa = a; opb = b; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    lat = 1;
    if (noise) begin
      bus.op_i = 2'($urandom); bus.len_i = 3'($urandom); bus.cin_i = 1'($urandom);
    end
    while (!bus.done_o && lat < 20) begin
      if (noise) bus.start_i = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", bus.done_o, 1'b1);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, cyc;
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.op_i = 2'b00; bus.len_i = 3'd0; bus.cin_i = 1'b0;
    opa = 64'd0; opb = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_done", bus.done_o, 1'b0);
    chk("rst_wr_en", bus.wr_en_o, 1'b0);
    chk("rst_carry", bus.carry_o, 1'b0);
    chk("rst_zero", bus.zero_o, 1'b0);
    chk("rst_rd_idx", bus.rd_idx_o, 3'd0);
    chk("rst_wr_idx", bus.wr_idx_o, 3'd0);
    chk("rst_wr_data", bus.wr_data_o, 8'd0);
    chk("rst_alu_cmd", bus.alu_cmd_o, 5'b01000);
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD 0x01FF + 0x0001
    wlog.delete();
    do_op(2'b00, 3'd1, 1'b0, 64'h01FF, 64'h0001, 1'b0, lat);
    chk("add_latency", lat, 3);
    chk("add_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("add_wr0", wlog[0], {3'd0, 8'h00});
      chk("add_wr1", wlog[1], {3'd1, 8'h02});
    end
    chk("add_carry", bus.carry_o, 1'b0);

    // LSR 0x000003
    wlog.delete(); rlog.delete();
    do_op(2'b11, 3'd2, 1'b0, 64'h000003, 64'h0, 1'b0, lat);
    chk("lsr_nrd", rlog.size(), 3);
    chk("lsr_nwr", wlog.size(), 3);
    if (rlog.size() == 3 && wlog.size() == 3) begin
      chk("lsr_rd", {rlog[0], rlog[1], rlog[2]}, {3'd2, 3'd1, 3'd0});
      chk("lsr_wr0", wlog[0], {3'd2, 8'h00});
      chk("lsr_wr1", wlog[1], {3'd1, 8'h00});
      chk("lsr_wr2", wlog[2], {3'd0, 8'h01});
    end
    chk("lsr_carry", bus.carry_o, 1'b1);

    // SUB single byte 5 - 3 with cin=1
    @(posedge clk); #1;
    bus.op_i = 2'b01; bus.len_i = 3'd0; bus.cin_i = 1'b1; opa = 64'h05; opb = 64'h03;
    bus.start_i = 1'b1;
    @(posedge clk); #1 bus.start_i = 1'b0;
    chk("sub_cmd", bus.alu_cmd_o, 5'b00001);
    chk("sub_sc", bus.alu_sc_o, 1'b1);
    @(posedge clk); #1;
    chk("sub_wr_en", bus.wr_en_o, 1'b1);
    chk("sub_done", bus.done_o, 1'b1);
    chk("sub_data", bus.wr_data_o, 8'h02);
    chk("sub_carry", bus.carry_o, 1'b1);
    @(posedge clk); #1;

    // aggregate zero
    do_op(2'b00, 3'd1, 1'b0, 64'h0000, 64'h0000, 1'b0, lat);
`ifdef MP_SEQ_ZERO_EN
    chk("zero_set", bus.zero_o, 1'b1);
`else
    chk("zero_set", bus.zero_o, 1'b0);
`endif
    do_op(2'b00, 3'd1, 1'b0, 64'h0100, 64'h0000, 1'b0, lat);
    chk("zero_clr", bus.zero_o, 1'b0);

    // start held high through a 4-byte ADD, back-to-back acceptance
    wlog.delete();
    @(posedge clk); #1;
    bus.op_i = 2'b00; bus.len_i = 3'd3; bus.cin_i = 1'b0;
    opa = 64'h8877_6655; opb = 64'h1122_33FF; bus.start_i = 1'b1;
    cyc = 0;
    while (!bus.done_o && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("hold_done", bus.done_o, 1'b1);
    @(posedge clk); #1;
    chk("hold_idle", bus.busy_o, 1'b0);
    chk("hold_nwr", wlog.size(), 4);
    @(posedge clk); #1;
    chk("hold_restart", bus.busy_o, 1'b1);
    bus.start_i = 1'b0;
    cyc = 0;
    while (!bus.done_o && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("hold_done2", bus.done_o, 1'b1);
    @(posedge clk); #1;
    chk("hold_nwr2", wlog.size(), 8);

    // reset in second RUN cycle of an 8-byte LSL
    @(posedge clk); #1;
    bus.op_i = 2'b10; bus.len_i = 3'd7; bus.cin_i = 1'b1;
    opa = 64'hDEAD_BEEF_0123_4567; bus.start_i = 1'b1;
    @(posedge clk); #1 bus.start_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy_o, 1'b0);
    chk("abort_wr_en", bus.wr_en_o, 1'b0);
    wlog.delete(); dcount = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_nwr", wlog.size(), 0);
    chk("abort_ndone", dcount, 0);

    // randomized operations with input noise while busy
    for (int i = 0; i < 60; i++) begin
      do_op(2'($urandom), 3'($urandom), 1'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, 1'b1, lat);
      chk("rand_latency", lat, int'(m_len) + 2);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
